// File: rtl/mux_pkg.sv
// Shared state encoding and width helper for the scanning channel multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Select/counter widths never collapse to zero, even for a count of 1.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N-to-1 slice selector; out-of-range selects yield zero.
module mux_nx1
    import mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 1,
    localparam int SELW = clog2_min1(NCH)
) (
    input  logic [NCH*W-1:0] in,
    input  logic [SELW-1:0]  sel,
    output logic [W-1:0]     out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel) == k) out = in[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 channel mux with manual select and timed round-robin scan.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | manual mode tracks sel each cycle; scan mode waits for start
//   SCAN  | each channel held DWELL cycles, channel 0 up to NCH-1
//   DONE  | one-cycle completion pulse, output held
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int DWELL = 10,
    localparam int SELW = clog2_min1(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  in,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              start,
    output logic [W-1:0]      out,
    output logic [SELW-1:0]   cur_sel,
    output logic              busy,
    output logic              done
);

    localparam int              CW       = clog2_min1(DWELL);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NCH - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SELW-1:0] mux_sel;
    logic [W-1:0]    mux_out;

    // One shared selector: the channel the next edge will load into out.
    always_comb begin
        mux_sel = cur_sel;
        case (state)
            IDLE: mux_sel = mode ? '0 : sel;
            SCAN: if (cnt == CNT_LAST && cur_sel != SEL_LAST) mux_sel = cur_sel + 1'b1;
            default: mux_sel = cur_sel;
        endcase
    end

    mux_nx1 #(
        .NCH(NCH),
        .W  (W)
    ) u_mux (
        .in (in),
        .sel(mux_sel),
        .out(mux_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= '0;
            cur_sel <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (!mode) begin
                        out     <= mux_out;
                        cur_sel <= sel;
                    end else if (start) begin
                        state   <= SCAN;
                        cur_sel <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        out     <= mux_out;
                    end
                end
                SCAN: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                        out <= mux_out;
                    end else if (cur_sel != SEL_LAST) begin
                        cur_sel <= mux_sel;
                        cnt     <= '0;
                        out     <= mux_out;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
